pad_host_rsp: RTL and testbench

//  Off-chip responder for the chip's PAD interface. Accepts one command beat from the chip.

---
 rtl/pad_pkg.sv | 21 ++
 rtl/pad_rsp_skid.sv | 51 +++++
 rtl/pad_host_rsp.sv | 157 +++++++++++++++
 tb/tb_pad_host_rsp.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_pkg.sv
// Shared definitions for the PAD command interface: FSM encodings and command field layout.
// Included by both the host-side responder and the chip-side command packer.
package pad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SRC  = 2'd1,
        SINK = 2'd2,
        FNH  = 2'd3
    } padState_t;

    // Command beat layout: {.., ReqNum, Addr, RdGLB}
    localparam int CMD_RD_BIT   = 0;
    localparam int CMD_ADDR_LSB = 1;

    // ReqNum sits directly above the Addr field, so its offset follows the field width.
    function automatic int cmdNumLsb(input int addrWidth);
        return CMD_ADDR_LSB + addrWidth;
    endfunction

endpackage

// File: rtl/pad_rsp_skid.sv
// Two-entry valid/ready FIFO buffering host-memory read data ahead of the PAD bus.
// The occupancy count is exported so the producer can issue reads against pop-aware credit.
module pad_rsp_skid #(
    parameter int WIDTH = 129
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pushValid,
    input  logic [WIDTH-1:0] pushData,
    input  logic             popReady,
    output logic             popValid,
    output logic [WIDTH-1:0] popData,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wrPtr;
    logic             rdPtr;
    logic             doPush;
    logic             doPop;

    assign popValid = (count != 2'd0);
    assign popData  = mem[rdPtr];
    assign doPop    = popValid && popReady;
    // A push into a full FIFO is legal only when the same cycle frees an entry.
    assign doPush   = pushValid && ((count != 2'd2) || doPop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wrPtr  <= 1'b0;
            rdPtr  <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= ~wrPtr;
            end
            if (doPop) begin
                rdPtr <= ~rdPtr;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pad_host_rsp.sv
// Host-side PAD responder: accepts one command beat, then sources host memory into the chip
// or sinks chip data into host memory. Valid/ready: a beat moves when Vld&Rdy share a cycle.
module pad_host_rsp
    import pad_pkg::*;
#(
    parameter int PORT_WIDTH     = 128,
    parameter int SRAM_WIDTH     = 256,
    parameter int ADDR_WIDTH     = 16,
    parameter int MEM_ADDR_WIDTH = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PORT_WIDTH-1:0]     ITFPAD_Dat,
    input  logic                      ITFPAD_DatVld,
    input  logic                      ITFPAD_DatLast,
    output logic                      PADITF_DatRdy,
    output logic [PORT_WIDTH-1:0]     PADITF_Dat,
    output logic                      PADITF_DatVld,
    output logic                      PADITF_DatLast,
    input  logic                      ITFPAD_DatRdy,
    output logic                      MemRdEn,
    output logic                      MemWrEn,
    output logic [MEM_ADDR_WIDTH-1:0] MemAddr,
    output logic [PORT_WIDTH-1:0]     MemWrDat,
    input  logic [PORT_WIDTH-1:0]     MemRdDat,
    output logic                      Done,
    output logic                      Err
);

    localparam int RATIO   = SRAM_WIDTH / PORT_WIDTH;
    localparam int RLOG    = $clog2(RATIO);
    localparam int CNT_W   = ADDR_WIDTH + RLOG;
    localparam int NUM_LSB = cmdNumLsb(ADDR_WIDTH);
    localparam int MAW     = MEM_ADDR_WIDTH;

    padState_t              state;
    padState_t              nextState;
    logic [CNT_W-1:0]       beats;
    logic [CNT_W-1:0]       issued;
    logic [CNT_W-1:0]       sent;
    logic [MAW-1:0]         baseAddr;
    logic                   inflight;
    logic                   inflightLast;
    logic                   rdyQ;
    logic                   errQ;

    logic                   cmdRd;
    logic [ADDR_WIDTH-1:0]  cmdAddr;
    logic [ADDR_WIDTH-1:0]  cmdNum;
    logic                   idleAcc;
    logic                   sinkAcc;
    logic                   sinkLastIdx;
    logic                   issue;
    logic                   pop;
    logic                   popLast;
    logic [2:0]             occ;

    logic                   skidVld;
    logic [PORT_WIDTH:0]    skidData;
    logic [1:0]             skidCnt;
    logic                   srcVld;

    assign cmdRd   = ITFPAD_Dat[CMD_RD_BIT];
    assign cmdAddr = ITFPAD_Dat[CMD_ADDR_LSB +: ADDR_WIDTH];
    assign cmdNum  = ITFPAD_Dat[NUM_LSB +: ADDR_WIDTH];

    assign idleAcc     = (state == IDLE) && ITFPAD_DatVld && rdyQ;
    assign sinkAcc     = (state == SINK) && ITFPAD_DatVld && rdyQ;
    assign sinkLastIdx = (sent == beats - CNT_W'(1));

    assign srcVld  = skidVld && (state == SRC);
    assign pop     = srcVld && ITFPAD_DatRdy;
    assign popLast = pop && skidData[PORT_WIDTH];
    // Entries held plus the read landing now, minus the beat leaving now, must stay below 2.
    assign occ     = 3'(skidCnt) + 3'(inflight) - 3'(pop);
    assign issue   = (state == SRC) && (issued < beats) && (occ < 3'd2);

    pad_rsp_skid #(
        .WIDTH (PORT_WIDTH + 1)
    ) uSkid (
        .clk       (clk),
        .rst_n     (rst_n),
        .pushValid (inflight),
        .pushData  ({inflightLast, MemRdDat}),
        .popReady  (pop),
        .popValid  (skidVld),
        .popData   (skidData),
        .count     (skidCnt)
    );

    always_comb begin
        nextState      = state;
        PADITF_DatRdy  = rdyQ;
        PADITF_DatVld  = srcVld;
        PADITF_DatLast = srcVld && skidData[PORT_WIDTH];
        PADITF_Dat     = '0;
        MemRdEn        = issue;
        MemWrEn        = sinkAcc;
        MemWrDat       = '0;
        MemAddr        = '0;
        Done           = (state == FNH);
        Err            = errQ;

        if (srcVld) PADITF_Dat = skidData[PORT_WIDTH-1:0];
        if (issue) MemAddr = baseAddr + MAW'(issued);
        if (sinkAcc) begin
            MemAddr  = baseAddr + MAW'(sent);
            MemWrDat = ITFPAD_Dat;
        end

        case (state)
            IDLE: begin
                if (idleAcc) begin
                    if (cmdNum == '0)  nextState = FNH;
                    else if (cmdRd)    nextState = SINK;
                    else               nextState = SRC;
                end
            end
            SRC:     if (popLast) nextState = FNH;
            SINK:    if (sinkAcc && (ITFPAD_DatLast || sinkLastIdx)) nextState = FNH;
            FNH:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Ready is registered so it reads 0 while in reset and follows the state from then on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rdyQ         <= 1'b0;
            errQ         <= 1'b0;
            beats        <= '0;
            baseAddr     <= '0;
            issued       <= '0;
            sent         <= '0;
            inflight     <= 1'b0;
            inflightLast <= 1'b0;
        end else begin
            state        <= nextState;
            rdyQ         <= (nextState == IDLE) || (nextState == SINK);
            inflight     <= issue;
            inflightLast <= issue && (issued == beats - CNT_W'(1));

            if (idleAcc) begin
                beats    <= CNT_W'(cmdNum) << RLOG;
                baseAddr <= MAW'(cmdAddr) << RLOG;
                issued   <= '0;
                sent     <= '0;
                errQ     <= !ITFPAD_DatLast;
            end
            if (issue) issued <= issued + CNT_W'(1);
            if (pop || sinkAcc) sent <= sent + CNT_W'(1);
            if (sinkAcc && (ITFPAD_DatLast != sinkLastIdx)) errQ <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pad_host_rsp.sv
// Directed bench for pad_host_rsp: sink vectors from a table, plus source, backpressure,
// zero-length and mid-transfer reset sequences against a small host-memory model.
module tb_pad_host_rsp;

    localparam int PW  = 128;
    localparam int MAW = 24;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [PW-1:0]  ITFPAD_Dat = '0;
    logic           ITFPAD_DatVld = 1'b0;
    logic           ITFPAD_DatLast = 1'b0;
    logic           PADITF_DatRdy;
    logic [PW-1:0]  PADITF_Dat;
    logic           PADITF_DatVld;
    logic           PADITF_DatLast;
    logic           ITFPAD_DatRdy = 1'b0;
    logic           MemRdEn;
    logic           MemWrEn;
    logic [MAW-1:0] MemAddr;
    logic [PW-1:0]  MemWrDat;
    logic [PW-1:0]  MemRdDat = '0;
    logic           Done;
    logic           Err;

    int total = 0;
    int bad   = 0;
    int nRd   = 0;
    int nWr   = 0;
    int nBoth = 0;

    logic [PW:0] exp_q[$];

    typedef struct {
        bit          rd;
        logic [15:0] addr;
        logic [15:0] num;
        bit          cmdLast;
        int          nBeats;
        int          lastAt;
        int          expWr;
        bit          expErr;
    } sinkVec_t;

    sinkVec_t vecs[7];

    pad_host_rsp dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ITFPAD_Dat     (ITFPAD_Dat),
        .ITFPAD_DatVld  (ITFPAD_DatVld),
        .ITFPAD_DatLast (ITFPAD_DatLast),
        .PADITF_DatRdy  (PADITF_DatRdy),
        .PADITF_Dat     (PADITF_Dat),
        .PADITF_DatVld  (PADITF_DatVld),
        .PADITF_DatLast (PADITF_DatLast),
        .ITFPAD_DatRdy  (ITFPAD_DatRdy),
        .MemRdEn        (MemRdEn),
        .MemWrEn        (MemWrEn),
        .MemAddr        (MemAddr),
        .MemWrDat       (MemWrDat),
        .MemRdDat       (MemRdDat),
        .Done           (Done),
        .Err            (Err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- host memory model ----------------
    function automatic logic [PW-1:0] memWord(input logic [MAW-1:0] a);
        return {8'hC3, a, 32'h1234_0000 ^ {8'h00, a}, ~{8'h00, a}, {a, 8'h5A}};
    endfunction

    always @(posedge clk) begin
        if (MemRdEn) MemRdDat <= memWord(MemAddr);
        else         MemRdDat <= {4{32'hDEAD_BEEF}};
    end

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (MemRdEn) nRd++;
            if (MemWrEn) nWr++;
            if (MemRdEn && MemWrEn) nBoth++;
        end
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    function automatic logic [PW-1:0] mkCmd(input bit rd, input logic [15:0] addr, input logic [15:0] num);
        logic [PW-1:0] c;
        c = '0;
        c[127:96] = 32'hFEED_F00D;
        c[0]     = rd;
        c[16:1]  = addr;
        c[32:17] = num;
        return c;
    endfunction

    task automatic sendCmd(input bit rd, input logic [15:0] addr, input logic [15:0] num, input bit last);
        @(negedge clk);
        ITFPAD_Dat     = mkCmd(rd, addr, num);
        ITFPAD_DatVld  = 1'b1;
        ITFPAD_DatLast = last;
        #1;
        check("cmd_rdy", PADITF_DatRdy, 1'b1);
        @(posedge clk);
        #1;
        ITFPAD_DatVld  = 1'b0;
        ITFPAD_DatLast = 1'b0;
        ITFPAD_Dat     = '0;
    endtask

    task automatic runSource(input logic [15:0] addr, input logic [15:0] num, input bit randRdy);
        int beats;
        int cyc;
        int got;
        int firstVld;
        int lastHs;
        bit prevStall;
        logic [PW:0] prevBeat;
        logic [PW:0] beat;
        logic [PW:0] expBeat;
        logic [MAW-1:0] base;
        beats = int'(num) * 2;
        cyc = 0; got = 0; firstVld = -1; lastHs = 0; prevStall = 1'b0; prevBeat = '0;
        base = MAW'(addr) * 24'd2;
        exp_q.delete();
        for (int k = 0; k < beats; k++)
            exp_q.push_back({(k == beats - 1), memWord(base + MAW'(k))});
        nRd = 0;
        ITFPAD_DatRdy = 1'b1;
        sendCmd(1'b0, addr, num, 1'b1);
        while (got < beats && cyc < 400) begin
            cyc++;
            @(negedge clk);
            ITFPAD_DatRdy = randRdy ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (cyc == 1) check("src_first_rd", {MemRdEn, MemAddr}, {1'b1, base});
            if (prevStall) check("src_hold_vld", PADITF_DatVld, 1'b1);
            if (PADITF_DatVld) begin
                beat = {PADITF_DatLast, PADITF_Dat};
                if (firstVld < 0) firstVld = cyc;
                if (prevStall) check("src_hold_dat", beat, prevBeat);
                if (ITFPAD_DatRdy) begin
                    expBeat = exp_q.pop_front();
                    check("src_beat", beat, expBeat);
                    got++;
                    lastHs = cyc;
                    prevStall = 1'b0;
                end else begin
                    prevStall = 1'b1;
                    prevBeat  = beat;
                end
            end else begin
                prevStall = 1'b0;
            end
        end
        check("src_got", got, beats);
        check("src_first_vld", firstVld, 3);
        if (!randRdy) check("src_b2b", lastHs - firstVld + 1, beats);
        @(negedge clk);
        ITFPAD_DatRdy = 1'b0;
        #1;
        check("src_done", {Done, Err, PADITF_DatVld}, 3'b100);
        @(negedge clk);
        #1;
        check("src_idle", {Done, PADITF_DatRdy, PADITF_DatVld}, 3'b010);
        check("src_nrd", nRd, beats);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [PW-1:0] d;
        int hs;
        int cyc;

        vecs[0] = '{1'b1, 16'h0010, 16'd2, 1'b1, 4,  3, 4, 1'b0};
        vecs[1] = '{1'b1, 16'h0040, 16'd2, 1'b1, 2,  1, 2, 1'b1};
        vecs[2] = '{1'b1, 16'h0003, 16'd2, 1'b1, 4, -1, 4, 1'b1};
        vecs[3] = '{1'b1, 16'hFFFF, 16'd1, 1'b1, 2,  1, 2, 1'b0};
        vecs[4] = '{1'b1, 16'h0007, 16'd0, 1'b1, 0, -1, 0, 1'b0};
        vecs[5] = '{1'b1, 16'h0002, 16'd1, 1'b0, 2,  1, 2, 1'b1};
        vecs[6] = '{1'b0, 16'h0009, 16'd0, 1'b1, 0, -1, 0, 1'b0};

        // Reset: outputs held at zero even with a command presented.
        rst_n          = 1'b0;
        ITFPAD_Dat     = mkCmd(1'b1, 16'h10, 16'd2);
        ITFPAD_DatVld  = 1'b1;
        ITFPAD_DatLast = 1'b1;
        ITFPAD_DatRdy  = 1'b1;
        #3;
        check("rst_ctl", {PADITF_DatRdy, PADITF_DatVld, PADITF_DatLast, MemRdEn, MemWrEn, Done, Err}, 7'd0);
        check("rst_dat", PADITF_Dat, '0);
        check("rst_wdat", MemWrDat, '0);
        check("rst_addr", MemAddr, '0);
        repeat (2) @(negedge clk);
        ITFPAD_DatVld = 1'b0;
        ITFPAD_DatRdy = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_rdy", {PADITF_DatRdy, Done, Err}, 3'b100);

        // Table: sink transfers, protocol errors, zero-length commands.
        for (int v = 0; v < 7; v++) begin
            nWr = 0;
            nRd = 0;
            sendCmd(vecs[v].rd, vecs[v].addr, vecs[v].num, vecs[v].cmdLast);
            check("tbl_err_cmd", Err, !vecs[v].cmdLast);
            for (int i = 0; i < vecs[v].nBeats; i++) begin
                if (i == 1) begin
                    @(negedge clk);
                    ITFPAD_DatVld = 1'b0;
                    #1;
                    check("tbl_bubble", {MemWrEn, Done}, 2'b00);
                end
                @(negedge clk);
                d = {$urandom(), $urandom(), $urandom(), $urandom()};
                ITFPAD_Dat     = d;
                ITFPAD_DatVld  = 1'b1;
                ITFPAD_DatLast = (i == vecs[v].lastAt);
                #1;
                check("tbl_wr", {MemWrEn, MemRdEn, PADITF_DatRdy, MemAddr},
                      {1'b1, 1'b0, 1'b1, MAW'(vecs[v].addr) * 24'd2 + MAW'(i)});
                check("tbl_wdat", MemWrDat, d);
            end
            @(negedge clk);
            ITFPAD_DatVld  = 1'b0;
            ITFPAD_DatLast = 1'b0;
            #1;
            check("tbl_done", {Done, Err, PADITF_DatRdy}, {1'b1, vecs[v].expErr, 1'b0});
            @(negedge clk);
            #1;
            check("tbl_idle", {Done, Err, PADITF_DatRdy}, {1'b0, vecs[v].expErr, 1'b1});
            check("tbl_nwr", nWr, vecs[v].expWr);
            check("tbl_nrd", nRd, 0);
        end

        // Source with the chip always ready, then with random backpressure.
        runSource(16'd5, 16'd3, 1'b0);
        runSource(16'd5, 16'd3, 1'b1);

        // Reset in the middle of a source transfer after three beats.
        ITFPAD_DatRdy = 1'b1;
        sendCmd(1'b0, 16'd5, 16'd3, 1'b1);
        hs = 0;
        cyc = 0;
        while (hs < 3 && cyc < 50) begin
            cyc++;
            @(negedge clk);
            #1;
            if (PADITF_DatVld && ITFPAD_DatRdy) hs++;
        end
        check("mid_hs", hs, 3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctl", {PADITF_DatRdy, PADITF_DatVld, PADITF_DatLast, MemRdEn, MemWrEn, Done, Err}, 7'd0);
        check("mid_rst_dat", PADITF_Dat, '0);
        check("mid_rst_addr", MemAddr, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runSource(16'd9, 16'd1, 1'b0);

        check("no_both_strobes", nBoth, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
